wb_copy_master: RTL and testbench
=================================

WB_COPY_MASTER -- requirements
Module: wb_copy_master

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning the number of cycles an access may wait for ack_i before it is aborted; legal range 1..65535.
REQ-002 clk_i  input  1  system clock; all logic is rising-edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 src_i  input  20  source byte address, sampled with start_i; bit 0 ignored (forced 0).
REQ-006 dst_i  input  20  destination byte address, sampled with start_i; bit 0 ignored (forced 0).
REQ-007 len_i  input  16  number of 16-bit words to copy, sampled with start_i.
REQ-008 busy_o  output  1  high from the cycle after an accepted start until the cycle done_o pulses.
REQ-009 done_o  output  1  one-cycle pulse at copy completion or abort.
REQ-010 err_o  output  1  sticky timeout flag; cleared by the next accepted start or by reset.
REQ-011 adr_o  output  20  Wishbone byte address.
REQ-012 dat_o  output  16  Wishbone write data.
REQ-013 dat_i  input  16  Wishbone read data, valid when ack_i=1.
REQ-014 we_o  output  1  Wishbone write enable.
REQ-015 stb_o  output  1  Wishbone strobe; there is no separate cyc.
REQ-016 byte_o  output  1  Wishbone byte-transfer select; held 0 because all transfers are words.
REQ-017 ack_i  input  1  Wishbone acknowledge from the slave.

Function
REQ-018 States SHALL be IDLE, RD, RGAP, WR, WGAP, and all outputs SHALL be registered.
REQ-019 IDLE behaviour:
- start_i=1 and len_i!=0: latch src, dst and count, set busy_o, clear err_o, go to RD at the next edge.
- start_i=1 and len_i=0: stay in IDLE, pulse done_o next cycle, clear err_o, issue no bus cycle.
REQ-020 RD SHALL drive stb_o=1, we_o=0, adr_o=src pointer.
- ack_i=1 at an edge: capture dat_i into the word buffer and go to RGAP.
REQ-021 RGAP SHALL hold stb_o=0 for exactly one cycle, then go to WR.
REQ-022 WR SHALL drive stb_o=1, we_o=1, adr_o=dst pointer, dat_o=buffer.
- ack_i=1 at an edge: src+=2, dst+=2, count-=1, go to WGAP.
REQ-023 WGAP SHALL hold stb_o=0 for one cycle.
- count=0: pulse done_o, clear busy_o, go to IDLE.
- otherwise: go to RD.
REQ-024 Pointers SHALL increment modulo 2^20, so 0xFFFFE+2 wraps to 0x00000.
REQ-025 Timing: a start accepted at edge N SHALL give stb_o=1 in cycle N+1, and with zero-wait acks one word SHALL take 4 cycles.
REQ-026 A per-access counter SHALL reset on entry to RD or WR.
- If TIMEOUT cycles elapse with no ack_i: deassert stb_o, set err_o, pulse done_o, clear busy_o, go to IDLE, and skip the remaining words.
REQ-027 start_i SHALL be ignored while busy_o=1.
REQ-028 ack_i SHALL be ignored in IDLE, RGAP and WGAP.
REQ-029 dat_o, adr_o and we_o SHALL stay stable while stb_o=1.
REQ-030 byte_o SHALL be 0 at all times.

Reset
REQ-031 While rst_i=1 at an edge, the block SHALL force the following at that same edge, including mid-copy with no further bus activity:
- state=IDLE
- stb_o=0, we_o=0, byte_o=0
- adr_o=0, dat_o=0
- busy_o=0, done_o=0, err_o=0
- count and pointers cleared

Verification
REQ-032 src=0x00100, dst=0x20000, len=3, zero-wait slave returning 0x1111/0x2222/0x3333 -> writes to 0x20000/0x20002/0x20004 with the same data, done_o after 12 cycles of bus activity, busy_o low in the cycle after done_o.
REQ-033 len=0 start -> done_o the next cycle, stb_o never asserted, busy_o stays 0.
REQ-034 src=0xFFFFE, dst=0x7FFFE, len=2 -> read addresses 0xFFFFE then 0x00000, write addresses 0x7FFFE then 0x80000.
REQ-035 TIMEOUT=8, slave never acks the first write -> stb_o drops after 8 cycles in WR, err_o=1, one done_o pulse, no further reads; a following good start clears err_o.
REQ-036 Slave inserting 3 wait states per access, with a second start_i pulsed mid-copy -> data correct, second start ignored, stb_o stable during waits.
REQ-037 rst_i asserted in WR of word 2 of 4 -> next cycle all outputs 0 and state IDLE; a new start then copies from freshly latched addresses.

Source files
------------

// File: rtl/wb_copy_master.sv
// Wishbone word-copy master: reads len 16-bit words starting at src and writes
// them to dst, one word at a time, with a one-cycle idle gap after each access.
// Every access can be aborted by a watchdog if the slave never acknowledges.
module wb_copy_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [19:0] src_i,
  input  logic [19:0] dst_i,
  input  logic [15:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [19:0] adr_o,
  output logic [15:0] dat_o,
  input  logic [15:0] dat_i,
  output logic        we_o,
  output logic        stb_o,
  output logic        byte_o,
  input  logic        ack_i
);

  typedef enum logic [2:0] {IDLE, RD, RGAP, WR, WGAP} state_t;

  // Watchdog fires at the end of the TIMEOUT-th unacknowledged strobe cycle.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [19:0] src_ptr, src_n;
  logic [19:0] dst_ptr, dst_n;
  logic [15:0] count, count_n;
  logic [15:0] word_buf, word_buf_n;
  logic [15:0] tmo, tmo_n;
  logic [19:0] adr_n;
  logic [15:0] dat_n;
  logic        busy_n, done_n, err_n, stb_n, we_n;

  // All transfers are full words.
  assign byte_o = 1'b0;

  // Next-state and next-output logic; every output is a registered copy of these.
  always_comb begin
    state_n    = state;
    src_n      = src_ptr;
    dst_n      = dst_ptr;
    count_n    = count;
    word_buf_n = word_buf;
    tmo_n      = tmo;
    adr_n      = adr_o;
    dat_n      = dat_o;
    busy_n     = busy_o;
    done_n     = 1'b0;
    err_n      = err_o;
    stb_n      = stb_o;
    we_n       = we_o;

    case (state)
      IDLE: begin
        if (start_i) begin
          err_n = 1'b0;
          if (len_i != 16'd0) begin
            src_n   = {src_i[19:1], 1'b0};
            dst_n   = {dst_i[19:1], 1'b0};
            count_n = len_i;
            busy_n  = 1'b1;
            stb_n   = 1'b1;
            we_n    = 1'b0;
            adr_n   = {src_i[19:1], 1'b0};
            tmo_n   = 16'd0;
            state_n = RD;
          end else begin
            // Empty copy: complete immediately without touching the bus.
            done_n = 1'b1;
          end
        end
      end

      RD: begin
        if (ack_i) begin
          word_buf_n = dat_i;
          stb_n      = 1'b0;
          state_n    = RGAP;
        end else if (tmo == TMO_LAST) begin
          stb_n   = 1'b0;
          we_n    = 1'b0;
          err_n   = 1'b1;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          tmo_n = tmo + 16'd1;
        end
      end

      RGAP: begin
        stb_n   = 1'b1;
        we_n    = 1'b1;
        adr_n   = dst_ptr;
        dat_n   = word_buf;
        tmo_n   = 16'd0;
        state_n = WR;
      end

      WR: begin
        if (ack_i) begin
          src_n   = src_ptr + 20'd2;
          dst_n   = dst_ptr + 20'd2;
          count_n = count - 16'd1;
          stb_n   = 1'b0;
          we_n    = 1'b0;
          state_n = WGAP;
        end else if (tmo == TMO_LAST) begin
          // Abort: the remaining words are abandoned.
          stb_n   = 1'b0;
          we_n    = 1'b0;
          err_n   = 1'b1;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          tmo_n = tmo + 16'd1;
        end
      end

      WGAP: begin
        if (count == 16'd0) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          stb_n   = 1'b1;
          we_n    = 1'b0;
          adr_n   = src_ptr;
          tmo_n   = 16'd0;
          state_n = RD;
        end
      end

      default: begin
        stb_n   = 1'b0;
        we_n    = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      src_ptr  <= 20'd0;
      dst_ptr  <= 20'd0;
      count    <= 16'd0;
      word_buf <= 16'd0;
      tmo      <= 16'd0;
      adr_o    <= 20'd0;
      dat_o    <= 16'd0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      stb_o    <= 1'b0;
      we_o     <= 1'b0;
    end else begin
      state    <= state_n;
      src_ptr  <= src_n;
      dst_ptr  <= dst_n;
      count    <= count_n;
      word_buf <= word_buf_n;
      tmo      <= tmo_n;
      adr_o    <= adr_n;
      dat_o    <= dat_n;
      busy_o   <= busy_n;
      done_o   <= done_n;
      err_o    <= err_n;
      stb_o    <= stb_n;
      we_o     <= we_n;
    end
  end

endmodule

// File: tb/tb_wb_copy_master.sv
// Bench for wb_copy_master: a word-memory slave with programmable wait states
// and a hang point, an expected-transaction scoreboard and a bus monitor.
module tb_wb_copy_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [19:0] src = 20'd0;
  logic [19:0] dst = 20'd0;
  logic [15:0] len = 16'd0;
  logic        busy, done, err, we, stb, byte_sel, ack;
  logic [19:0] adr;
  logic [15:0] wdat, rdat;

  wb_copy_master #(.TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .src_i(src), .dst_i(dst),
    .len_i(len), .busy_o(busy), .done_o(done), .err_o(err), .adr_o(adr),
    .dat_o(wdat), .dat_i(rdat), .we_o(we), .stb_o(stb), .byte_o(byte_sel),
    .ack_i(ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Slave memory: preloaded words override a fixed address hash.
  logic [15:0] pre [logic [19:0]];

  function automatic logic [15:0] rd_data(logic [19:0] a);
    if (pre.exists(a)) return pre[a];
    return 16'(a * 7 + 3) ^ 16'hA5C3;
  endfunction

  // Slave behaviour knobs.
  int ws = 0;          // wait states per access
  int hang_at = -1;    // handshake index that is never acknowledged (-1: none)
  int acks = 0;
  int acks_base = 0;
  int wcnt = 0;

  assign ack = stb && (wcnt >= ws) && (hang_at < 0 || (acks - acks_base) < hang_at);

  always_comb rdat = rd_data(adr);

  always @(posedge clk) begin
    if (!stb || ack) wcnt <= 0;
    else             wcnt <= wcnt + 1;
    if (stb && ack)  acks <= acks + 1;
  end

  // Scoreboard queues.
  typedef struct {
    logic        we;
    logic [19:0] adr;
    logic [15:0] dat;
  } xact_t;

  xact_t exq[$];
  logic  dq[$];

  // Monitor: checks every handshake, done pulse and bus invariant.
  logic        p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_done = 1'b0;
  logic [19:0] p_adr = 20'd0;
  logic [15:0] p_dat = 16'd0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("byte_zero", {31'd0, byte_sel}, 32'd0);
      if (stb) chk("stb_implies_busy", {31'd0, busy}, 32'd1);
      if (p_stb && !p_ack && stb) begin
        chk("stable_adr", {12'd0, adr}, {12'd0, p_adr});
        chk("stable_we", {31'd0, we}, {31'd0, p_we});
        chk("stable_dat", {16'd0, wdat}, {16'd0, p_dat});
      end
      if (stb && ack) begin
        if (exq.size() == 0) begin
          chk("unexpected_xact", {11'd0, we, adr}, 32'hFFFFFFFF);
        end else begin
          xact_t e;
          e = exq.pop_front();
          chk("xact_we", {31'd0, we}, {31'd0, e.we});
          chk("xact_adr", {12'd0, adr}, {12'd0, e.adr});
          if (e.we) chk("xact_wdat", {16'd0, wdat}, {16'd0, e.dat});
        end
      end
      if (done) begin
        chk("done_single", {31'd0, p_done}, 32'd0);
        if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else                chk("done_err", {31'd0, err}, {31'd0, dq.pop_front()});
      end
    end
    p_stb  = stb;
    p_ack  = ack;
    p_we   = we;
    p_adr  = adr;
    p_dat  = wdat;
    p_done = done;
  end

  // Queue the reference bus traffic for one copy and run it to completion.
  task automatic do_copy(input logic [19:0] s, input logic [19:0] d,
                         input logic [15:0] n, input int w, input int hang,
                         input bit mid);
    logic [19:0] sb, db, ra;
    int          k, total, expk;
    bit          seen, exp_err;
    xact_t       x;
    sb = {s[19:1], 1'b0};
    db = {d[19:1], 1'b0};
    total = 2 * int'(n);
    exp_err = (hang >= 0) && (hang < total);
    for (int i = 0; i < total; i++) begin
      if (exp_err && i >= hang) break;
      ra = sb + 20'(2 * (i / 2));
      x.we  = (i % 2 == 1);
      x.adr = x.we ? db + 20'(2 * (i / 2)) : ra;
      x.dat = rd_data(ra);
      exq.push_back(x);
    end
    dq.push_back(exp_err);
    expk = exp_err ? hang * (w + 2) + TMO + 1 : int'(n) * (2 * w + 4) + 1;

    @(posedge clk); #2;
    ws = w; hang_at = hang; acks_base = acks;
    start = 1'b1; src = s; dst = d; len = n;
    k = 0; seen = 0;
    while (!seen && k < 3000) begin
      @(posedge clk); #2;
      k++;
      if (k == 1) begin
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, {31'd0, n != 16'd0});
        chk("stb_after_start", {31'd0, stb}, {31'd0, n != 16'd0});
        chk("err_cleared", {31'd0, err}, 32'd0);
      end
      if (mid && k == 3) begin
        start = 1'b1; src = 20'(s + 20'h1234); dst = 20'(d + 20'h0400); len = 16'd7;
      end
      if (k == 4) start = 1'b0;
      if (done) seen = 1;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    if (seen) chk("done_cycle", 32'(k), 32'(expk));
    @(posedge clk); #2;
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_after_done", {31'd0, done}, 32'd0);
    chk("queue_drained", 32'(exq.size()), 32'd0);
    hang_at = -1;
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_stb", {31'd0, stb}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_adr", {12'd0, adr}, 32'd0);
    chk("rst_dat", {16'd0, wdat}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    pre[20'h00100] = 16'h1111;
    pre[20'h00102] = 16'h2222;
    pre[20'h00104] = 16'h3333;
    do_copy(20'h00100, 20'h20000, 16'd3, 0, -1, 0);

    do_copy(20'h00200, 20'h30000, 16'd0, 0, -1, 0);

    do_copy(20'hFFFFE, 20'h7FFFE, 16'd2, 0, -1, 0);

    // Slave never acks the first write.
    do_copy(20'h01000, 20'h02000, 16'd3, 0, 1, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk("idle_no_stb", {31'd0, stb}, 32'd0);
    do_copy(20'h01000, 20'h02000, 16'd1, 0, -1, 0);
    chk("err_cleared_after_good", {31'd0, err}, 32'd0);

    do_copy(20'h04000, 20'h05000, 16'd4, 3, -1, 1);

    // Reset during the write of word 2 of 4.
    begin
      xact_t x;
      for (int i = 0; i < 8; i++) begin
        x.we  = (i % 2 == 1);
        x.adr = x.we ? 20'h09000 + 20'(2 * (i / 2)) : 20'h08000 + 20'(2 * (i / 2));
        x.dat = rd_data(20'h08000 + 20'(2 * (i / 2)));
        exq.push_back(x);
      end
      dq.push_back(1'b0);
      @(posedge clk); #2;
      ws = 3; acks_base = acks;
      start = 1'b1; src = 20'h08000; dst = 20'h09000; len = 16'd4;
      @(posedge clk); #2;
      start = 1'b0;
      k = 0;
      while (!(stb && we && (acks - acks_base) == 3) && k < 200) begin
        @(posedge clk); #2;
        k++;
      end
      chk("reached_word2_write", {31'd0, stb && we}, 32'd1);
      rst = 1'b1;
      exq.delete();
      dq.delete();
      @(posedge clk); #2;
      rst = 1'b0;
      chk("midrst_stb", {31'd0, stb}, 32'd0);
      chk("midrst_we", {31'd0, we}, 32'd0);
      chk("midrst_adr", {12'd0, adr}, 32'd0);
      chk("midrst_dat", {16'd0, wdat}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_err", {31'd0, err}, 32'd0);
      repeat (4) begin
        @(posedge clk); #2;
        chk("midrst_quiet", {31'd0, stb}, 32'd0);
      end
    end
    do_copy(20'h0A000, 20'h0B000, 16'd2, 0, -1, 0);

    for (int t = 0; t < 6; t++) begin
      do_copy(20'($urandom), 20'($urandom), 16'($urandom_range(1, 5)),
              int'($urandom_range(0, 3)), -1, bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
